// File: rtl/ps2_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ps2_pkg                                                      |
// | Description : PS/2 set-2 protocol byte values, parser state encoding, the   |
// |               default key make codes and a control-byte classifier.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package ps2_pkg;

    // Sequence prefixes
    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_PAUSE  = 8'hE1;

    // Keyboard-to-host control / status bytes (never part of a key sequence)
    localparam logic [7:0] PS2_BAT_OK = 8'hAA;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_ERR0   = 8'h00;
    localparam logic [7:0] PS2_ERR1   = 8'hFF;

    // Parser states
    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_EXT        = 3'd1;
    localparam logic [2:0] ST_BRK        = 3'd2;
    localparam logic [2:0] ST_EXT_BRK    = 3'd3;
    localparam logic [2:0] ST_PAUSE_SKIP = 3'd4;

    // Pause/Break sends E1 followed by seven more bytes that carry no key info
    localparam logic [2:0] PAUSE_SKIP_LEN = 3'd7;

    // Movement key make codes (KEY_UP is an E0-extended code)
    localparam logic [7:0] KEY_W  = 8'h1D;
    localparam logic [7:0] KEY_S  = 8'h1B;
    localparam logic [7:0] KEY_A  = 8'h1C;
    localparam logic [7:0] KEY_D  = 8'h23;
    localparam logic [7:0] KEY_UP = 8'h75;

    function automatic logic is_ctrl_code(input logic [7:0] code);
        return (code == PS2_BAT_OK) || (code == PS2_ACK)  || (code == PS2_RESEND) ||
               (code == PS2_ECHO)   || (code == PS2_ERR0) || (code == PS2_ERR1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_repeat_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ps2_repeat_timer                                             |
// | Description : Per-key auto-repeat generator. Loads REPEAT_DELAY-1 on press, |
// |               counts down while held, pulses o_repeat on reaching zero and  |
// |               reloads REPEAT_PERIOD-1. Release clears the count and wins    |
// |               over a coincident repeat.                                     |
// | Ports       : clk, rst (async, active-high), i_start (press), i_stop        |
// |               (release), i_held (current level), o_repeat (1-cycle pulse)   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ps2_repeat_timer #(
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    input  logic i_stop,
    input  logic i_held,
    output logic o_repeat
);

    localparam int c_max_count = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int c_cnt_w     = $clog2(c_max_count);
    localparam logic [c_cnt_w-1:0] c_delay_load  = c_cnt_w'(REPEAT_DELAY - 1);
    localparam logic [c_cnt_w-1:0] c_period_load = c_cnt_w'(REPEAT_PERIOD - 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic               r_repeat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_repeat <= 1'b0;
        end else if (i_stop) begin
            // Release suppresses a repeat that would land on the same cycle
            r_cnt    <= '0;
            r_repeat <= 1'b0;
        end else if (i_start) begin
            r_cnt    <= c_delay_load;
            r_repeat <= 1'b0;
        end else if (i_held) begin
            if (r_cnt == '0) begin
                r_cnt    <= c_period_load;
                r_repeat <= 1'b1;
            end else begin
                r_cnt    <= r_cnt - 1'b1;
                r_repeat <= 1'b0;
            end
        end else begin
            r_repeat <= 1'b0;
        end
    end

    assign o_repeat = r_repeat;

endmodule
`default_nettype wire

// File: rtl/ps2_keyset_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ps2_keyset_tracker                                           |
// | Description : Tracks held state of NUM_KEYS PS/2 set-2 keys (with optional  |
// |               E0 extension) from a validated scancode stream; produces      |
// |               held levels, press/release pulses and timed auto-repeat.      |
// | Ports       : clock, reset (async, active-high)                            |
// |               scancode[7:0], scancode_valid, clear_all        (inputs)      |
// |               key_held, key_press, key_release, key_repeat [NUM_KEYS-1:0]   |
// |               any_held, unknown_code                           (outputs)     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ps2_keyset_tracker
    import ps2_pkg::*;
#(
    parameter int                      NUM_KEYS      = 4,
    parameter logic [8*NUM_KEYS-1:0]   KEY_CODES     = {KEY_D, KEY_A, KEY_S, KEY_W},
    parameter logic [NUM_KEYS-1:0]     KEY_EXT       = '0,
    parameter int                      REPEAT_DELAY  = 25000000,
    parameter int                      REPEAT_PERIOD = 5000000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [7:0]          scancode,
    input  logic                scancode_valid,
    input  logic                clear_all,
    output logic [NUM_KEYS-1:0] key_held,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_repeat,
    output logic                any_held,
    output logic                unknown_code
);

    logic [2:0]          r_state;
    logic [2:0]          r_skip;
    logic [NUM_KEYS-1:0] r_held;
    logic [NUM_KEYS-1:0] r_press;
    logic [NUM_KEYS-1:0] r_release;
    logic                r_unknown;

    logic [2:0]          w_state_nxt;
    logic [2:0]          w_skip_nxt;
    logic                w_byte_ok;
    logic                w_make;
    logic                w_brk;
    logic                w_ext;
    logic [NUM_KEYS-1:0] w_match;
    logic [NUM_KEYS-1:0] w_press;
    logic [NUM_KEYS-1:0] w_release;
    logic                w_unknown;

    // A byte arriving together with clear_all is dropped
    assign w_byte_ok = scancode_valid && !clear_all;

    // ------------------------------------------------------------------------
    // Parser: classifies the completing byte of a sequence as make or break
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_skip_nxt  = r_skip;
        w_make      = 1'b0;
        w_brk       = 1'b0;
        w_ext       = 1'b0;
        if (w_byte_ok) begin
            if (r_state == ST_PAUSE_SKIP) begin
                // Pause payload is opaque, even bytes that look like control codes
                if (r_skip <= 3'd1) begin
                    w_state_nxt = ST_IDLE;
                    w_skip_nxt  = 3'd0;
                end else begin
                    w_skip_nxt  = r_skip - 3'd1;
                end
            end else if (is_ctrl_code(scancode)) begin
                w_state_nxt = ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (scancode == PS2_EXT) begin
                            w_state_nxt = ST_EXT;
                        end else if (scancode == PS2_BRK) begin
                            w_state_nxt = ST_BRK;
                        end else if (scancode == PS2_PAUSE) begin
                            w_state_nxt = ST_PAUSE_SKIP;
                            w_skip_nxt  = PAUSE_SKIP_LEN;
                        end else begin
                            w_make = 1'b1;
                        end
                    end
                    ST_EXT: begin
                        if (scancode == PS2_BRK) begin
                            w_state_nxt = ST_EXT_BRK;
                        end else begin
                            w_make      = 1'b1;
                            w_ext       = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end
                    end
                    ST_BRK: begin
                        w_brk       = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                    ST_EXT_BRK: begin
                        w_brk       = 1'b1;
                        w_ext       = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                    default: begin
                        w_state_nxt = ST_IDLE;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------------
    // Key matching: every key whose code and extension flag agree is updated
    // ------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_match
            assign w_match[gi] = (scancode == KEY_CODES[8*gi +: 8]) && (w_ext == KEY_EXT[gi]);
        end
    endgenerate

    // Typematic makes on a held key and breaks on an idle key are no-ops
    assign w_press   = {NUM_KEYS{w_make}} & w_match & ~r_held;
    assign w_release = clear_all ? r_held : ({NUM_KEYS{w_brk}} & w_match & r_held);
    assign w_unknown = (w_make || w_brk) && (w_match == '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_skip    <= 3'd0;
            r_held    <= '0;
            r_press   <= '0;
            r_release <= '0;
            r_unknown <= 1'b0;
        end else begin
            if (clear_all) begin
                r_state <= ST_IDLE;
                r_skip  <= 3'd0;
            end else begin
                r_state <= w_state_nxt;
                r_skip  <= w_skip_nxt;
            end
            r_held    <= (r_held | w_press) & ~w_release;
            r_press   <= w_press;
            r_release <= w_release;
            r_unknown <= w_unknown;
        end
    end

    // ------------------------------------------------------------------------
    // Per-key auto-repeat timers
    // ------------------------------------------------------------------------
    generate
        for (genvar gk = 0; gk < NUM_KEYS; gk++) begin : g_repeat
            ps2_repeat_timer #(
                .REPEAT_DELAY  (REPEAT_DELAY),
                .REPEAT_PERIOD (REPEAT_PERIOD)
            ) u_timer (
                .clk      (clock),
                .rst      (reset),
                .i_start  (w_press[gk]),
                .i_stop   (w_release[gk]),
                .i_held   (r_held[gk]),
                .o_repeat (key_repeat[gk])
            );
        end
    endgenerate

    assign key_held     = r_held;
    assign key_press    = r_press;
    assign key_release  = r_release;
    assign any_held     = |r_held;
    assign unknown_code = r_unknown;

endmodule
`default_nettype wire

// File: tb/tb_ps2_keyset_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ps2_keyset_tracker                                        |
// | Description : Self-checking bench for ps2_keyset_tracker. Two instances:   |
// |               A uses plain W/S/A/D codes, B maps key 0 to extended 75.      |
// |               Both use REPEAT_DELAY=10, REPEAT_PERIOD=4.                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_ps2_keyset_tracker;

    localparam logic [3:0] NONE = 4'b0000;
    localparam logic [3:0] K0   = 4'b0001;
    localparam logic [3:0] K1   = 4'b0010;
    localparam logic [3:0] K2   = 4'b0100;
    localparam logic       Y    = 1'b1;
    localparam logic       N    = 1'b0;

    typedef struct packed {
        logic [3:0] held;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] rpt;
        logic       any;
        logic       unknown;
    } obs_t;

    typedef struct {
        logic       rst;   // apply a reset before this row
        logic       sel;   // 0: check instance A, 1: check instance B
        logic       v;
        logic [7:0] b;
        logic       clr;
        obs_t       exp;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] scancode;
    logic       scancode_valid;
    logic       clear_all;

    logic [3:0] a_held, a_press, a_release, a_repeat;
    logic       a_any, a_unknown;
    logic [3:0] b_held, b_press, b_release, b_repeat;
    logic       b_any, b_unknown;

    obs_t exp_q[$];
    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_rpt = 0;

    always #5 clock = ~clock;

    ps2_keyset_tracker #(
        .NUM_KEYS(4), .KEY_CODES(32'h231C1B1D), .KEY_EXT(4'b0000),
        .REPEAT_DELAY(10), .REPEAT_PERIOD(4)
    ) u_dut_a (
        .clock(clock), .reset(reset), .scancode(scancode),
        .scancode_valid(scancode_valid), .clear_all(clear_all),
        .key_held(a_held), .key_press(a_press), .key_release(a_release),
        .key_repeat(a_repeat), .any_held(a_any), .unknown_code(a_unknown)
    );

    ps2_keyset_tracker #(
        .NUM_KEYS(4), .KEY_CODES(32'h231C1B75), .KEY_EXT(4'b0001),
        .REPEAT_DELAY(10), .REPEAT_PERIOD(4)
    ) u_dut_b (
        .clock(clock), .reset(reset), .scancode(scancode),
        .scancode_valid(scancode_valid), .clear_all(clear_all),
        .key_held(b_held), .key_press(b_press), .key_release(b_release),
        .key_repeat(b_repeat), .any_held(b_any), .unknown_code(b_unknown)
    );

    function automatic obs_t o(input logic [3:0] h, input logic [3:0] p,
                               input logic [3:0] r, input logic [3:0] rp, input logic u);
        obs_t e;
        e = '{held: h, press: p, rel: r, rpt: rp, any: |h, unknown: u};
        return e;
    endfunction

    function automatic vec_t mk(input logic rst, input logic sel, input logic v,
                                input logic [7:0] b, input logic clr, input obs_t e);
        vec_t t;
        t.rst = rst; t.sel = sel; t.v = v; t.b = b; t.clr = clr; t.exp = e;
        return t;
    endfunction

    task automatic check(input logic sel, input string name);
        obs_t got;
        obs_t want;
        want = exp_q.pop_front();
        if (sel)
            got = '{held: b_held, press: b_press, rel: b_release, rpt: b_repeat, any: b_any, unknown: b_unknown};
        else
            got = '{held: a_held, press: a_press, rel: a_release, rpt: a_repeat, any: a_any, unknown: a_unknown};
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got held=%b press=%b rel=%b rpt=%b any=%b unk=%b, want held=%b press=%b rel=%b rpt=%b any=%b unk=%b",
                     name, got.held, got.press, got.rel, got.rpt, got.any, got.unknown,
                     want.held, want.press, want.rel, want.rpt, want.any, want.unknown);
        end
    endtask

    // Drive one cycle of stimulus, then compare the registered response
    task automatic drive(input logic sel, input logic v, input logic [7:0] b,
                         input logic clr, input obs_t e, input string name);
        scancode_valid = v;
        scancode       = b;
        clear_all      = clr;
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        scancode_valid = 1'b0;
        clear_all      = 1'b0;
        check(sel, name);
    endtask

    task automatic do_reset(input string name);
        scancode_valid = 1'b0;
        clear_all      = 1'b0;
        reset          = 1'b1;
        #1;
        exp_q.push_back(o(NONE, NONE, NONE, NONE, N));
        check(1'b0, name);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        scancode       = 8'h00;
        scancode_valid = 1'b0;
        clear_all      = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        exp_q.push_back(o(NONE, NONE, NONE, NONE, N));
        check(1'b0, "reset_a");
        exp_q.push_back(o(NONE, NONE, NONE, NONE, N));
        check(1'b1, "reset_b");
        reset = 1'b0;

        // Basic press / typematic / release / unknown / break of idle key
        tbl.push_back(mk(Y, N, Y, 8'h1D, N, o(K0,   K0,   NONE, NONE, N)));
        tbl.push_back(mk(N, N, Y, 8'h1D, N, o(K0,   NONE, NONE, NONE, N)));
        tbl.push_back(mk(N, N, Y, 8'hF0, N, o(K0,   NONE, NONE, NONE, N)));
        tbl.push_back(mk(N, N, Y, 8'h1D, N, o(NONE, NONE, K0,   NONE, N)));
        tbl.push_back(mk(N, N, N, 8'h1D, N, o(NONE, NONE, NONE, NONE, N)));
        tbl.push_back(mk(N, N, Y, 8'h33, N, o(NONE, NONE, NONE, NONE, Y)));
        tbl.push_back(mk(N, N, Y, 8'hF0, N, o(NONE, NONE, NONE, NONE, N)));
        tbl.push_back(mk(N, N, Y, 8'h33, N, o(NONE, NONE, NONE, NONE, Y)));
        tbl.push_back(mk(N, N, Y, 8'hF0, N, o(NONE, NONE, NONE, NONE, N)));
        tbl.push_back(mk(N, N, Y, 8'h1C, N, o(NONE, NONE, NONE, NONE, N)));
        // Two keys: releasing key 0 leaves key 1 untouched
        tbl.push_back(mk(Y, N, Y, 8'h1D, N, o(K0,   K0,   NONE, NONE, N)));
        tbl.push_back(mk(N, N, Y, 8'h1B, N, o(K0|K1, K1,  NONE, NONE, N)));
        tbl.push_back(mk(N, N, Y, 8'hF0, N, o(K0|K1, NONE, NONE, NONE, N)));
        tbl.push_back(mk(N, N, Y, 8'h1D, N, o(K1,   NONE, K0,   NONE, N)));
        tbl.push_back(mk(N, N, Y, 8'hF0, N, o(K1,   NONE, NONE, NONE, N)));
        tbl.push_back(mk(N, N, Y, 8'h1B, N, o(NONE, NONE, K1,   NONE, N)));
        // Pause sequence is skipped silently, then a normal make
        tbl.push_back(mk(Y, N, Y, 8'hE1, N, o(NONE, NONE, NONE, NONE, N)));
        tbl.push_back(mk(N, N, Y, 8'h14, N, o(NONE, NONE, NONE, NONE, N)));
        tbl.push_back(mk(N, N, Y, 8'h77, N, o(NONE, NONE, NONE, NONE, N)));
        tbl.push_back(mk(N, N, Y, 8'hE1, N, o(NONE, NONE, NONE, NONE, N)));
        tbl.push_back(mk(N, N, Y, 8'hF0, N, o(NONE, NONE, NONE, NONE, N)));
        tbl.push_back(mk(N, N, Y, 8'h14, N, o(NONE, NONE, NONE, NONE, N)));
        tbl.push_back(mk(N, N, Y, 8'hF0, N, o(NONE, NONE, NONE, NONE, N)));
        tbl.push_back(mk(N, N, Y, 8'h77, N, o(NONE, NONE, NONE, NONE, N)));
        tbl.push_back(mk(N, N, Y, 8'h1D, N, o(K0,   K0,   NONE, NONE, N)));
        tbl.push_back(mk(N, N, Y, 8'hF0, N, o(K0,   NONE, NONE, NONE, N)));
        tbl.push_back(mk(N, N, Y, 8'h1D, N, o(NONE, NONE, K0,   NONE, N)));
        // Control bytes abort partial sequences: E0 AA 1D and F0 FA 1D
        tbl.push_back(mk(N, N, Y, 8'hE0, N, o(NONE, NONE, NONE, NONE, N)));
        tbl.push_back(mk(N, N, Y, 8'hAA, N, o(NONE, NONE, NONE, NONE, N)));
        tbl.push_back(mk(N, N, Y, 8'h1D, N, o(K0,   K0,   NONE, NONE, N)));
        tbl.push_back(mk(N, N, Y, 8'hF0, N, o(K0,   NONE, NONE, NONE, N)));
        tbl.push_back(mk(N, N, Y, 8'hFA, N, o(K0,   NONE, NONE, NONE, N)));
        tbl.push_back(mk(N, N, Y, 8'h1D, N, o(K0,   NONE, NONE, NONE, N)));
        tbl.push_back(mk(N, N, Y, 8'hF0, N, o(K0,   NONE, NONE, NONE, N)));
        tbl.push_back(mk(N, N, Y, 8'h1D, N, o(NONE, NONE, K0,   NONE, N)));
        // Extended key on instance B
        tbl.push_back(mk(Y, Y, Y, 8'h75, N, o(NONE, NONE, NONE, NONE, Y)));
        tbl.push_back(mk(N, Y, Y, 8'hE0, N, o(NONE, NONE, NONE, NONE, N)));
        tbl.push_back(mk(N, Y, Y, 8'h75, N, o(K0,   K0,   NONE, NONE, N)));
        tbl.push_back(mk(N, Y, Y, 8'hE0, N, o(K0,   NONE, NONE, NONE, N)));
        tbl.push_back(mk(N, Y, Y, 8'hF0, N, o(K0,   NONE, NONE, NONE, N)));
        tbl.push_back(mk(N, Y, Y, 8'h75, N, o(NONE, NONE, K0,   NONE, N)));
        tbl.push_back(mk(N, Y, Y, 8'hE0, N, o(NONE, NONE, NONE, NONE, N)));
        tbl.push_back(mk(N, Y, Y, 8'h1C, N, o(NONE, NONE, NONE, NONE, Y)));
        // clear_all beats a simultaneous byte; clear_all also resets the parser
        tbl.push_back(mk(Y, N, Y, 8'h1D, N, o(K0,   K0,   NONE, NONE, N)));
        tbl.push_back(mk(N, N, Y, 8'h1C, N, o(K0|K2, K2,  NONE, NONE, N)));
        tbl.push_back(mk(N, N, Y, 8'h1B, Y, o(NONE, NONE, K0|K2, NONE, N)));
        tbl.push_back(mk(N, N, N, 8'h1B, N, o(NONE, NONE, NONE, NONE, N)));
        tbl.push_back(mk(N, N, Y, 8'hE0, N, o(NONE, NONE, NONE, NONE, N)));
        tbl.push_back(mk(N, N, N, 8'h00, Y, o(NONE, NONE, NONE, NONE, N)));
        tbl.push_back(mk(N, N, Y, 8'h1D, N, o(K0,   K0,   NONE, NONE, N)));
        tbl.push_back(mk(N, N, Y, 8'hF0, N, o(K0,   NONE, NONE, NONE, N)));
        tbl.push_back(mk(N, N, Y, 8'h1D, N, o(NONE, NONE, K0,   NONE, N)));

        foreach (tbl[i]) begin
            if (tbl[i].rst)
                do_reset($sformatf("vec%0d_reset", i));
            drive(tbl[i].sel, tbl[i].v, tbl[i].b, tbl[i].clr, tbl[i].exp, $sformatf("vec%0d", i));
        end

        // Reset in the middle of E0 F0 drops the sequence without a release
        do_reset("mid_reset_pre");
        drive(N, Y, 8'h1D, N, o(K0, K0,   NONE, NONE, N), "mid_press");
        drive(N, Y, 8'hE0, N, o(K0, NONE, NONE, NONE, N), "mid_e0");
        drive(N, Y, 8'hF0, N, o(K0, NONE, NONE, NONE, N), "mid_f0");
        do_reset("mid_reset");
        drive(N, N, 8'h00, N, o(NONE, NONE, NONE, NONE, N), "mid_idle");
        drive(N, Y, 8'h1D, N, o(K0,   K0,   NONE, NONE, N), "mid_make");
        drive(N, Y, 8'hF0, N, o(K0,   NONE, NONE, NONE, N), "mid_f0b");
        drive(N, Y, 8'h1D, N, o(NONE, NONE, K0,   NONE, N), "mid_rel");

        // Auto-repeat: press at k=0, typematic make at k=5, release lands at
        // k=30 where a repeat would otherwise fall
        do_reset("rpt_reset");
        for (int k = 0; k < 32; k++) begin
            logic       v_k;
            logic [7:0] b_k;
            logic [3:0] h_k;
            logic [3:0] p_k;
            logic [3:0] r_k;
            logic [3:0] rp_k;
            v_k  = (k == 0) || (k == 5) || (k == 29) || (k == 30);
            b_k  = (k == 29) ? 8'hF0 : 8'h1D;
            h_k  = (k < 30) ? K0 : NONE;
            p_k  = (k == 0) ? K0 : NONE;
            r_k  = (k == 30) ? K0 : NONE;
            rp_k = ((k >= 10) && (k < 30) && (((k - 10) % 4) == 0)) ? K0 : NONE;
            drive(N, v_k, b_k, N, o(h_k, p_k, r_k, rp_k, N), $sformatf("rpt_k%0d", k));
            if (a_repeat[0])
                n_rpt++;
        end
        n_cmp++;
        if (n_rpt != 5) begin
            n_bad++;
            $display("FAIL rpt_count: got %0d pulses, want 5", n_rpt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
